// File: rtl/audio_fir_sequencer_if.sv
// Codec and channel-filter signal bundle owned by audio_fir_sequencer.
// The master side is the sequencer; the slave side is the codec and filter pair.
interface audio_fir_sequencer_if #(
  parameter int DATA_W = 24
);
  logic                     read_ready;
  logic                     write_ready;
  logic signed [DATA_W-1:0] readdata_left;
  logic signed [DATA_W-1:0] readdata_right;
  logic signed [DATA_W-1:0] filt_out_left;
  logic signed [DATA_W-1:0] filt_out_right;

  logic                     read;
  logic                     write;
  logic signed [DATA_W-1:0] writedata_left;
  logic signed [DATA_W-1:0] writedata_right;
  logic signed [DATA_W-1:0] filt_temp_left;
  logic signed [DATA_W-1:0] filt_temp_right;
  logic                     filt_en;
  logic                     filt_clr;

  modport master (
    input  read_ready, write_ready, readdata_left, readdata_right,
           filt_out_left, filt_out_right,
    output read, write, writedata_left, writedata_right,
           filt_temp_left, filt_temp_right, filt_en, filt_clr
  );

  modport slave (
    output read_ready, write_ready, readdata_left, readdata_right,
           filt_out_left, filt_out_right,
    input  read, write, writedata_left, writedata_right,
           filt_temp_left, filt_temp_right, filt_en, filt_clr
  );
endinterface

// File: rtl/audio_fir_sequencer.sv
// Per-frame sequencer: codec read -> stereo FIR filter step -> codec write,
// with bypass, deferred filter-history flush, write timeout and sample counters.
module audio_fir_sequencer #(
  parameter int DATA_W     = 24,
  parameter int CNT_W      = 16,
  parameter int DROP_W     = 8,
  parameter int WR_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bypass,
  input  logic                  flush_req,
  audio_fir_sequencer_if.master bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      sample_count,
  output logic [DROP_W-1:0]     drop_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_FILTER, S_WAIT_WR, S_WRITE
  } state_t;

  localparam int TMR_W = (WR_TIMEOUT > 2) ? $clog2(WR_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WR_TIMEOUT - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     w_flush;
  logic                     w_read_d;
  logic                     w_write_d;
  logic                     w_filt_en_d;
  logic                     w_filt_clr_d;
  logic                     w_busy_d;
  logic                     w_drop;

  logic                     r_flush_pending;
  logic [TMR_W-1:0]         r_timer;
  logic                     r_read;
  logic                     r_write;
  logic                     r_filt_en;
  logic                     r_filt_clr;
  logic                     r_busy;
  logic signed [DATA_W-1:0] r_filt_temp_left;
  logic signed [DATA_W-1:0] r_filt_temp_right;
  logic signed [DATA_W-1:0] r_writedata_left;
  logic signed [DATA_W-1:0] r_writedata_right;
  logic [CNT_W-1:0]         r_sample_count;
  logic [DROP_W-1:0]        r_drop_count;

  // A request arriving in the same IDLE cycle as read_ready still wins.
  assign w_flush = r_flush_pending | flush_req;

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this comb block latch-free.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_flush)             w_next_state = S_CLEAR;
        else if (bus.read_ready) w_next_state = S_READ;
      end
      S_CLEAR:  w_next_state = S_IDLE;
      S_READ:   w_next_state = S_FILTER;
      S_FILTER: w_next_state = S_WAIT_WR;
      S_WAIT_WR: begin
        if (bus.write_ready)          w_next_state = S_WRITE;
        else if (r_timer == TMR_LAST) w_next_state = S_IDLE;
      end
      S_WRITE:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so each one is
  // high for exactly the cycle spent in its state.
  always_comb begin
    w_read_d     = (w_next_state == S_READ);
    w_write_d    = (w_next_state == S_WRITE);
    w_filt_en_d  = (w_next_state == S_FILTER);
    w_filt_clr_d = (w_next_state == S_CLEAR);
    w_busy_d     = (w_next_state != S_IDLE);
    w_drop       = (r_state == S_WAIT_WR) && !bus.write_ready && (r_timer == TMR_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush_pending   <= 1'b0;
      r_timer           <= '0;
      r_read            <= 1'b0;
      r_write           <= 1'b0;
      r_filt_en         <= 1'b0;
      r_filt_clr        <= 1'b0;
      r_busy            <= 1'b0;
      r_filt_temp_left  <= '0;
      r_filt_temp_right <= '0;
      r_writedata_left  <= '0;
      r_writedata_right <= '0;
      r_sample_count    <= '0;
      r_drop_count      <= '0;
    end else begin
      r_flush_pending <= (w_next_state == S_CLEAR) ? 1'b0 : w_flush;
      r_read          <= w_read_d;
      r_write         <= w_write_d;
      r_filt_en       <= w_filt_en_d;
      r_filt_clr      <= w_filt_clr_d;
      r_busy          <= w_busy_d;

      if (r_state == S_READ) begin
        r_filt_temp_left  <= bus.readdata_left;
        r_filt_temp_right <= bus.readdata_right;
      end

      // filt_out already reflects the new filt_temp while filt_en is high.
      if (r_state == S_FILTER) begin
        r_writedata_left  <= bypass ? r_filt_temp_left  : bus.filt_out_left;
        r_writedata_right <= bypass ? r_filt_temp_right : bus.filt_out_right;
        r_timer           <= '0;
      end else if (r_state == S_WAIT_WR) begin
        r_timer <= r_timer + TMR_W'(1);
      end

      if (w_write_d)                     r_sample_count <= r_sample_count + CNT_W'(1);
      if (w_drop && (r_drop_count != '1)) r_drop_count   <= r_drop_count + DROP_W'(1);
    end
  end

  assign bus.read            = r_read;
  assign bus.write           = r_write;
  assign bus.filt_en         = r_filt_en;
  assign bus.filt_clr        = r_filt_clr;
  assign bus.filt_temp_left  = r_filt_temp_left;
  assign bus.filt_temp_right = r_filt_temp_right;
  assign bus.writedata_left  = r_writedata_left;
  assign bus.writedata_right = r_writedata_right;
  assign busy                = r_busy;
  assign sample_count        = r_sample_count;
  assign drop_count          = r_drop_count;

endmodule

// File: tb/tb_audio_fir_sequencer.sv
// Bench for audio_fir_sequencer: 8-tap averaging filters as the environment,
// a table of directed frames, random frames against a queue model, reset abort and drop saturation.
module tb_audio_fir_sequencer;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 16;
  localparam int DROP_W = 8;
  localparam int WR_TO  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              bypass = 1'b0;
  logic              flush_req = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  sample_count;
  logic [DROP_W-1:0] drop_count;

  audio_fir_sequencer_if #(.DATA_W(DATA_W)) bus ();

  audio_fir_sequencer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .DROP_W(DROP_W), .WR_TIMEOUT(WR_TO)
  ) dut (
    .clk(clk), .reset(reset), .bypass(bypass), .flush_req(flush_req),
    .bus(bus), .busy(busy), .sample_count(sample_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Environment: two 8-tap moving-average filters (output = (new + 7 history) / 8).
  logic signed [DATA_W-1:0] hist_l [7];
  logic signed [DATA_W-1:0] hist_r [7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 7; i++) begin hist_l[i] <= '0; hist_r[i] <= '0; end
    end else if (bus.filt_clr) begin
      for (int i = 0; i < 7; i++) begin hist_l[i] <= '0; hist_r[i] <= '0; end
    end else if (bus.filt_en) begin
      hist_l[0] <= bus.filt_temp_left;
      hist_r[0] <= bus.filt_temp_right;
      for (int i = 1; i < 7; i++) begin hist_l[i] <= hist_l[i-1]; hist_r[i] <= hist_r[i-1]; end
    end
  end

  always_comb begin
    longint sl;
    longint sr;
    sl = longint'(bus.filt_temp_left);
    sr = longint'(bus.filt_temp_right);
    for (int i = 0; i < 7; i++) begin
      sl = sl + longint'(hist_l[i]);
      sr = sr + longint'(hist_r[i]);
    end
    bus.filt_out_left  = DATA_W'(sl >>> 3);
    bus.filt_out_right = DATA_W'(sr >>> 3);
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel sample history since the last flush.
  longint q_l[$];
  longint q_r[$];
  bit     model_flush = 1'b0;
  int     exp_cnt  = 0;
  int     exp_drop = 0;

  function automatic longint floor_div8(input longint s);
    longint q;
    q = s / 8;
    if ((s % 8 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_sample(input int l, input int r, input bit byp,
                                       output int el, output int er);
    longint sl = 0;
    longint sr = 0;
    q_l.push_back(l);
    q_r.push_back(r);
    if (q_l.size() > 8) void'(q_l.pop_front());
    if (q_r.size() > 8) void'(q_r.pop_front());
    foreach (q_l[i]) sl += q_l[i];
    foreach (q_r[i]) sr += q_r[i];
    el = byp ? l : int'(floor_div8(sl));
    er = byp ? r : int'(floor_div8(sr));
  endfunction

  // One codec frame starting in IDLE; d = WAIT_WR cycles before write_ready (>= WR_TO drops).
  task automatic do_frame(input int l, input int r, input bit byp, input int d, input bit fl,
                          input bit use_tab, input int tl, input int tr);
    int el, er;
    bit clr_first;
    bit done = 1'b0;
    clr_first = model_flush;
    if (clr_first) begin q_l.delete(); q_r.delete(); model_flush = 1'b0; end
    model_sample(l, r, byp, el, er);
    if (use_tab) begin el = tl; er = tr; end

    check("idle_before_frame", DATA_W'(busy), 0);
    bus.read_ready     = 1'b1;
    bus.readdata_left  = DATA_W'(l);
    bus.readdata_right = DATA_W'(r);
    bypass             = byp;
    bus.write_ready    = 1'b0;
    @(negedge clk);
    if (clr_first) begin
      check("clear_cycle{clr,rd,busy}", DATA_W'({bus.filt_clr, bus.read, busy}), DATA_W'(3'b101));
      @(negedge clk);
      check("after_clear{busy,clr,rd}", DATA_W'({busy, bus.filt_clr, bus.read}), 0);
      @(negedge clk);
    end
    check("read_cycle{rd,en,wr}", DATA_W'({bus.read, bus.filt_en, bus.write}), DATA_W'(3'b100));
    bus.read_ready = 1'b0;
    @(negedge clk);
    check("filter_cycle{rd,en}", DATA_W'({bus.read, bus.filt_en}), DATA_W'(2'b01));
    check("filt_temp_left", bus.filt_temp_left, DATA_W'(l));
    check("filt_temp_right", bus.filt_temp_right, DATA_W'(r));
    for (int k = 0; k < WR_TO && !done; k++) begin
      @(negedge clk);
      check("wait_no_write", DATA_W'({bus.write, busy}), DATA_W'(2'b01));
      flush_req       = fl && (k == 0);
      bus.write_ready = (k == d);
      if (k == d) done = 1'b1;
    end
    @(negedge clk);
    flush_req       = 1'b0;
    bus.write_ready = 1'b0;
    if (done) begin
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check("write_strobe", DATA_W'(bus.write), 1);
      check("writedata_left", bus.writedata_left, DATA_W'(el));
      check("writedata_right", bus.writedata_right, DATA_W'(er));
      @(negedge clk);
    end else begin
      if (exp_drop < (1 << DROP_W) - 1) exp_drop++;
    end
    check("back_idle{busy,wr}", DATA_W'({busy, bus.write}), 0);
    check("sample_count", DATA_W'(sample_count), DATA_W'(exp_cnt));
    check("drop_count", DATA_W'(drop_count), DATA_W'(exp_drop));
    if (fl) model_flush = 1'b1;
  endtask

  typedef struct {
    int l; int r; bit byp; int d; bit fl; int el; int er;
  } vec_t;

  vec_t tab [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.read_ready     = 1'b0;
    bus.write_ready    = 1'b0;
    bus.readdata_left  = '0;
    bus.readdata_right = '0;

    // Directed frames: ramp, bypass, flush, write-ready boundary, drop, negative averages.
    for (int i = 0; i < 8; i++) tab[i] = '{64, 128, 1'b0, 0, 1'b0, 8 * (i + 1), 16 * (i + 1)};
    tab[8]  = '{-96,  31,  1'b1, 0, 1'b0, -96,  31};
    tab[9]  = '{64,   128, 1'b0, 0, 1'b1, 44,   115};
    tab[10] = '{64,   128, 1'b0, 0, 1'b0, 8,    16};
    tab[11] = '{64,   128, 1'b0, 2, 1'b0, 16,   32};
    tab[12] = '{40,   -40, 1'b0, 3, 1'b0, 21,   27};
    tab[13] = '{8,    8,   1'b0, 4, 1'b0, 0,    0};
    tab[14] = '{0,    0,   1'b0, 0, 1'b0, 22,   28};
    tab[15] = '{-1,   -1,  1'b0, 1, 1'b0, 21,   27};
    tab[16] = '{-500, -500, 1'b0, 0, 1'b0, -41, -35};

    // Reset and idle.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_strobes", DATA_W'({busy, bus.read, bus.write, bus.filt_en, bus.filt_clr}), 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_strobes", DATA_W'({busy, bus.read, bus.write, bus.filt_en, bus.filt_clr}), 0);
    end
    check("idle_writedata_left", bus.writedata_left, 0);
    check("idle_filt_temp_right", bus.filt_temp_right, 0);
    check("idle_sample_count", DATA_W'(sample_count), 0);
    check("idle_drop_count", DATA_W'(drop_count), 0);

    foreach (tab[i])
      do_frame(tab[i].l, tab[i].r, tab[i].byp, tab[i].d, tab[i].fl, 1'b1, tab[i].el, tab[i].er);

    // Random frames checked against the queue model.
    for (int i = 0; i < 150; i++) begin
      logic signed [DATA_W-1:0] rl, rr;
      rl = DATA_W'($urandom);
      rr = DATA_W'($urandom);
      do_frame(int'(rl), int'(rr), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
               ($urandom_range(0, 7) == 0), 1'b0, 0, 0);
    end

    // Asynchronous reset during WAIT_WR aborts the sample.
    bus.read_ready     = 1'b1;
    bus.readdata_left  = 24'sd100;
    bus.readdata_right = 24'sd200;
    @(negedge clk);
    bus.read_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.write_ready = 1'b1;
    #2 reset = 1'b0;
    #1 check("abort_strobes", DATA_W'({busy, bus.write, bus.read, bus.filt_en}), 0);
    check("abort_sample_count", DATA_W'(sample_count), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_no_write", DATA_W'({busy, bus.write}), 0);
    end
    bus.write_ready = 1'b0;
    q_l.delete(); q_r.delete();
    model_flush = 1'b0;
    exp_cnt  = 0;
    exp_drop = 0;

    // Repeated timeouts: drop_count saturates, sample_count never moves.
    for (int i = 0; i < 300; i++)
      do_frame(int'($urandom_range(0, 1000)), 7, 1'b0, WR_TO, 1'b0, 1'b0, 0, 0);
    check("drop_saturated", DATA_W'(drop_count), DATA_W'((1 << DROP_W) - 1));
    check("no_samples_written", DATA_W'(sample_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
